// File: rtl/axi4_lite_reg_bank_irq_ctrl.sv
// AXI4-Lite register bank with per-source edge/level IRQ capture, W1C status, enable mask and registered ps_irq.
// Optional IRQ_COUNT register at index num_regs+3 when AXI4_LITE_IRQ_COUNT_EN is defined.
module axi4_lite_reg_bank_irq_ctrl #(
    parameter int unsigned         num_regs    = 2,
    parameter int unsigned         addr_width  = 7,
    parameter logic [num_regs-1:0] allow_write = {num_regs{1'b1}},
    parameter int unsigned         num_irq     = 1,
    parameter logic [num_irq-1:0]  irq_edge    = {num_irq{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [num_irq-1:0]       irq,
    output logic                     ps_irq,
    output logic                     irq_reset,
    output logic [32*num_regs-1:0]   reg_val,
    input  logic [32*num_regs-1:0]   reg_in,
    input  logic [addr_width-1:0]    s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [addr_width-1:0]    s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready
);

    localparam int unsigned IDX_STATUS = num_regs;
    localparam int unsigned IDX_ENABLE = num_regs + 1;
    localparam int unsigned IDX_RAW    = num_regs + 2;
`ifdef AXI4_LITE_IRQ_COUNT_EN
    localparam int unsigned IDX_COUNT  = num_regs + 3;
    localparam int unsigned IDX_LAST   = num_regs + 3;
`else
    localparam int unsigned IDX_LAST   = num_regs + 2;
`endif
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [addr_width-1:0] awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           regs_q [num_regs];
    logic [31:0]           regs_d [num_regs];
    logic [num_irq-1:0]    enable_q, enable_d, pending_q, pending_d, irq_prev_q;
    logic [num_irq-1:0]    irq_set, irq_clr;
    logic                  ps_irq_q, ps_irq_d, irq_reset_q, irq_reset_d;

    logic                  aw_hs, w_hs, ar_hs, do_write;
    logic [addr_width-1:0] wr_addr;
    logic [31:0]           wr_data, wr_mask, rd_data;
    logic [3:0]            wr_strb;
    logic [1:0]            rd_resp;
    int unsigned           widx, ridx;
    logic                  unused_ok;

    assign aw_hs    = awready_q & s_axi_awvalid;
    assign w_hs     = wready_q & s_axi_wvalid;
    assign ar_hs    = arready_q & s_axi_arvalid;
    // A beat arriving this cycle is used directly so the update lands one cycle after the last beat.
    assign do_write = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    assign wr_addr  = aw_held_q ? awaddr_q : s_axi_awaddr;
    assign wr_data  = w_held_q ? wdata_q : s_axi_wdata;
    assign wr_strb  = w_held_q ? wstrb_q : s_axi_wstrb;
    assign wr_mask  = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign widx     = 32'(wr_addr[addr_width-1:2]);
    assign ridx     = 32'(s_axi_araddr[addr_width-1:2]);
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0], reg_in};

    always_comb begin
        aw_held_d = aw_held_q | aw_hs;
        w_held_d  = w_held_q | w_hs;
        awaddr_d  = aw_hs ? s_axi_awaddr : awaddr_q;
        wdata_d   = w_hs ? s_axi_wdata : wdata_q;
        wstrb_d   = w_hs ? s_axi_wstrb : wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
        if (do_write) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (widx > IDX_LAST) ? RESP_SLVERR : RESP_OKAY;
        end
        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
    end

    always_comb begin
        for (int unsigned i = 0; i < num_regs; i++) begin
            regs_d[i] = regs_q[i];
            if (!allow_write[i])
                regs_d[i] = reg_in[32*i +: 32];
            else if (do_write && widx == i)
                regs_d[i] = (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
        end
        enable_d = enable_q;
        irq_clr  = '0;
        for (int unsigned i = 0; i < num_irq; i++) begin
            if (do_write && widx == IDX_ENABLE && wr_mask[i]) enable_d[i] = wr_data[i];
            if (do_write && widx == IDX_STATUS) irq_clr[i] = wr_mask[i] & wr_data[i];
            irq_set[i] = irq_edge[i] ? (irq[i] & ~irq_prev_q[i]) : irq[i];
        end
        pending_d   = irq_set | (pending_q & ~irq_clr);
        ps_irq_d    = |(pending_q & enable_q);
        irq_reset_d = do_write && (widx == IDX_STATUS);
    end

`ifdef AXI4_LITE_IRQ_COUNT_EN
    logic [31:0] count_q, count_d;
    always_comb begin
        count_d = (do_write && widx == IDX_COUNT) ? '0 : count_q;
        if (ps_irq_d && !ps_irq_q && count_d != '1) count_d = count_d + 32'd1;
    end
`endif

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (ridx < num_regs) begin
            for (int unsigned i = 0; i < num_regs; i++)
                if (ridx == i) rd_data = regs_q[i];
        end else if (ridx == IDX_STATUS) begin
            rd_data[num_irq-1:0] = pending_q;
        end else if (ridx == IDX_ENABLE) begin
            rd_data[num_irq-1:0] = enable_q;
        end else if (ridx == IDX_RAW) begin
            rd_data[num_irq-1:0] = irq;
`ifdef AXI4_LITE_IRQ_COUNT_EN
        end else if (ridx == IDX_COUNT) begin
            rd_data = count_q;
`endif
        end else begin
            rd_resp = RESP_SLVERR;
        end
        rdata_d  = ar_hs ? rd_data : rdata_q;
        rresp_d  = ar_hs ? rd_resp : rresp_q;
        rvalid_d = ar_hs | (rvalid_q & ~s_axi_rready);
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            for (int unsigned i = 0; i < num_regs; i++) regs_q[i] <= '0;
            enable_q    <= '0;
            pending_q   <= '0;
            irq_prev_q  <= '0;
            ps_irq_q    <= 1'b0;
            irq_reset_q <= 1'b0;
`ifdef AXI4_LITE_IRQ_COUNT_EN
            count_q     <= '0;
`endif
        end else begin
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            for (int unsigned i = 0; i < num_regs; i++) regs_q[i] <= regs_d[i];
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            irq_prev_q  <= irq;
            ps_irq_q    <= ps_irq_d;
            irq_reset_q <= irq_reset_d;
`ifdef AXI4_LITE_IRQ_COUNT_EN
            count_q     <= count_d;
`endif
        end
    end

    for (genvar g = 0; g < num_regs; g++) begin : g_reg_val
        assign reg_val[32*g +: 32] = regs_q[g];
    end

    assign ps_irq        = ps_irq_q;
    assign irq_reset     = irq_reset_q;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi4_lite_reg_bank_irq_ctrl.sv
// Self-checking bench: two general regs (reg1 read-only), two IRQ sources (bit0 level, bit1 edge).
// Read/write responses are checked against scoreboard queues filled when each transaction is issued.
module tb_axi4_lite_reg_bank_irq_ctrl;

    localparam logic [31:0] RIN1 = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  irq = '0;
    logic        ps_irq, irq_reset;
    logic [63:0] reg_val;
    logic [63:0] reg_in = {RIN1, 32'hAAAA_5555};
    logic [6:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;

    typedef struct { logic [31:0] d; logic [1:0] r; } rexp_t;
    rexp_t      rq[$];
    logic [1:0] bq[$];
    int total = 0, bad = 0, irq_rst_cnt = 0;

    axi4_lite_reg_bank_irq_ctrl #(
        .num_regs(2), .addr_width(7), .allow_write(2'b01), .num_irq(2), .irq_edge(2'b10)
    ) dut (
        .clk(clk), .rst(rst), .irq(irq), .ps_irq(ps_irq), .irq_reset(irq_reset),
        .reg_val(reg_val), .reg_in(reg_in),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (irq_reset) irq_rst_cnt++;

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awdly, input int wdly, input logic [1:0] er, output int bcyc);
        bit aw_done = 0, w_done = 0, b_done = 0;
        int cyc = 0;
        logic [1:0] e;
        bcyc = -1;
        bq.push_back(er);
        awaddr = a; wdata = d; wstrb = s; bready = 1;
        while (!b_done && cyc < 60) begin
            awvalid = !aw_done && cyc >= awdly;
            wvalid  = !w_done && cyc >= wdly;
            @(negedge clk);
            if (bvalid && bcyc < 0) bcyc = cyc;
            if (bvalid && bready) begin
                e = bq.pop_front();
                total++;
                if (bresp !== e) begin bad++; $display("FAIL bresp a=%h: got %b expected %b", a, bresp, e); end
                b_done = 1;
            end
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        awvalid = 0; wvalid = 0; bready = 0;
        if (!b_done) begin
            void'(bq.pop_front());
            total++; bad++;
            $display("FAIL write_timeout a=%h: got no bvalid expected bvalid", a);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        int bc;
        do_write(a, d, s, 0, 0, er, bc);
    endtask

    task automatic do_read(input logic [6:0] a, input logic [31:0] ed, input logic [1:0] er, input int hold);
        bit ar_done = 0, done = 0;
        int cyc = 0, cnt = 0;
        logic [31:0] first;
        rexp_t e;
        rq.push_back('{d: ed, r: er});
        araddr = a; arvalid = 1; rready = 0;
        while (!ar_done && cyc < 20) begin
            @(negedge clk);
            if (arvalid && arready) ar_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 0;
        while (ar_done && !done && cnt < hold + 20) begin
            rready = (cnt >= hold);
            @(negedge clk);
            if (cnt == 0) begin
                total++;
                if (rvalid !== 1'b1) begin bad++; $display("FAIL rd_latency a=%h: got rvalid=%b expected 1", a, rvalid); end
                first = rdata;
            end else if (cnt <= hold) begin
                total++;
                if (rvalid !== 1'b1 || rdata !== first) begin
                    bad++; $display("FAIL rd_hold a=%h: got rvalid=%b rdata=%h expected 1 %h", a, rvalid, rdata, first);
                end
            end
            if (rvalid && rready) begin
                e = rq.pop_front();
                total++;
                if (rdata !== e.d || rresp !== e.r) begin
                    bad++; $display("FAIL read a=%h: got %h/%b expected %h/%b", a, rdata, rresp, e.d, e.r);
                end
                done = 1;
            end
            @(posedge clk); #1;
            cnt++;
        end
        rready = 0;
        if (!done) begin
            if (rq.size() > 0) void'(rq.pop_front());
            total++; bad++;
            $display("FAIL read_timeout a=%h: got no rvalid expected rvalid", a);
        end else begin
            @(negedge clk);
            total++;
            if (rvalid !== 1'b0 || arready !== 1'b1) begin
                bad++; $display("FAIL rd_release: got rvalid=%b arready=%b expected 0 1", rvalid, arready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_val, ps_irq, irq_reset} !== '0) begin
            bad++; $display("FAIL reset_outputs: got aw%b w%b ar%b b%b r%b rd=%h rv=%h expected all zero",
                            awready, wready, arready, bvalid, rvalid, rdata, reg_val);
        end
        @(posedge clk); #1; rst = 0;
        cycles(2);
        @(negedge clk);
        total++;
        if (awready !== 1 || wready !== 1 || arready !== 1 || reg_val[63:32] !== RIN1) begin
            bad++; $display("FAIL post_reset: got aw%b w%b ar%b reg1=%h expected 1 1 1 %h",
                            awready, wready, arready, reg_val[63:32], RIN1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_strobe();
        int bc;
        do_write(7'h00, 32'hDEAD_BEEF, 4'b0101, 0, 3, 2'b00, bc);
        total++;
        if (bc !== 4) begin bad++; $display("FAIL bvalid_cycle_aw_first: got %0d expected 4", bc); end
        total++;
        if (reg_val[31:0] !== 32'h00AD_00EF) begin bad++; $display("FAIL strobe_reg0: got %h expected 00ad00ef", reg_val[31:0]); end
        do_read(7'h00, 32'h00AD_00EF, 2'b00, 0);
        do_write(7'h00, 32'h1122_3344, 4'b1010, 2, 0, 2'b00, bc);
        total++;
        if (bc !== 3) begin bad++; $display("FAIL bvalid_cycle_w_first: got %0d expected 3", bc); end
        do_write(7'h00, 32'h5566_7788, 4'b1111, 0, 0, 2'b00, bc);
        total++;
        if (bc !== 1) begin bad++; $display("FAIL bvalid_cycle_same: got %0d expected 1", bc); end
        do_read(7'h00, 32'h5566_7788, 2'b00, 0);
    endtask

    task automatic test_map();
        wr(7'h04, 32'hFFFF_FFFF, 4'b1111, 2'b00);
        total++;
        if (reg_val[63:32] !== RIN1) begin bad++; $display("FAIL ro_reg1: got %h expected %h", reg_val[63:32], RIN1); end
        do_read(7'h04, RIN1, 2'b00, 0);
        wr(7'h10, 32'hFFFF_FFFF, 4'b1111, 2'b00);
        irq = 2'b01;
        cycles(1);
        do_read(7'h10, 32'h1, 2'b00, 0);
        irq = 2'b00;
        do_read(7'h18, 32'h0, 2'b10, 3);
        wr(7'h18, 32'hFFFF_FFFF, 4'b1111, 2'b10);
        wr(7'h0C, 32'hFFFF_FFFF, 4'b1111, 2'b00);
        do_read(7'h0C, 32'h3, 2'b00, 0);
        wr(7'h0C, 32'h0, 4'b0000, 2'b00);
        do_read(7'h0C, 32'h3, 2'b00, 0);
        wr(7'h0C, 32'h0, 4'b0001, 2'b00);
        wr(7'h08, 32'h3, 4'b0001, 2'b00);
        do_read(7'h08, 32'h0, 2'b00, 0);
    endtask

    task automatic test_level_irq();
        logic [2:0] seen;
        wr(7'h0C, 32'h1, 4'b0001, 2'b00);
        irq = 2'b01;
        @(negedge clk); seen[0] = ps_irq;
        @(posedge clk); #1; irq = 2'b00;
        @(negedge clk); seen[1] = ps_irq;
        @(posedge clk); #1;
        @(negedge clk); seen[2] = ps_irq;
        total++;
        if (seen !== 3'b100) begin bad++; $display("FAIL ps_irq_latency: got %b expected 100", seen); end
        @(posedge clk); #1;
        cycles(3);
        do_read(7'h08, 32'h1, 2'b00, 0);
        wr(7'h08, 32'h1, 4'b0001, 2'b00);
        @(negedge clk);
        total++;
        if (ps_irq !== 1'b0) begin bad++; $display("FAIL ps_irq_clear: got %b expected 0", ps_irq); end
        @(posedge clk); #1;
        irq = 2'b10;
        cycles(1);
        irq = 2'b00;
        cycles(3);
        @(negedge clk);
        total++;
        if (ps_irq !== 1'b0) begin bad++; $display("FAIL masked_ps_irq: got %b expected 0", ps_irq); end
        @(posedge clk); #1;
        do_read(7'h08, 32'h2, 2'b00, 0);
        wr(7'h08, 32'h2, 4'b0001, 2'b00);
    endtask

    task automatic test_edge_w1c();
        int snap;
        wr(7'h0C, 32'h2, 4'b0001, 2'b00);
        irq = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) begin
                total++;
                if (ps_irq !== 1'b1) begin bad++; $display("FAIL edge_set: got %b expected 1", ps_irq); end
            end
            @(posedge clk); #1;
        end
        snap = irq_rst_cnt;
        wr(7'h08, 32'h2, 4'b0001, 2'b00);
        @(negedge clk);
        total++;
        if (ps_irq !== 1'b0) begin bad++; $display("FAIL edge_clear: got %b expected 0", ps_irq); end
        @(posedge clk); #1;
        cycles(1);
        @(negedge clk);
        total++;
        if (ps_irq !== 1'b0) begin bad++; $display("FAIL edge_no_reset: got %b expected 0", ps_irq); end
        @(posedge clk); #1;
        irq = 2'b00;
        do_read(7'h08, 32'h0, 2'b00, 0);
        total++;
        if (irq_rst_cnt - snap !== 1) begin bad++; $display("FAIL irq_reset_pulses: got %0d expected 1", irq_rst_cnt - snap); end
    endtask

    task automatic test_set_wins();
        int snap;
        wr(7'h0C, 32'h1, 4'b0001, 2'b00);
        irq = 2'b01;
        cycles(3);
        snap = irq_rst_cnt;
        wr(7'h08, 32'h1, 4'b0001, 2'b00);
        cycles(1);
        @(negedge clk);
        total++;
        if (ps_irq !== 1'b1) begin bad++; $display("FAIL set_wins_ps_irq: got %b expected 1", ps_irq); end
        @(posedge clk); #1;
        do_read(7'h08, 32'h1, 2'b00, 0);
        total++;
        if (irq_rst_cnt - snap !== 1) begin bad++; $display("FAIL set_wins_irq_reset: got %0d expected 1", irq_rst_cnt - snap); end
        irq = 2'b00;
        cycles(1);
        snap = irq_rst_cnt;
        wr(7'h08, 32'hFFFF_FFFF, 4'b1110, 2'b00);
        do_read(7'h08, 32'h1, 2'b00, 0);
        wr(7'h08, 32'h1, 4'b0000, 2'b00);
        do_read(7'h08, 32'h1, 2'b00, 0);
        total++;
        if (irq_rst_cnt - snap !== 2) begin bad++; $display("FAIL unstrobed_irq_reset: got %0d expected 2", irq_rst_cnt - snap); end
        wr(7'h08, 32'h1, 4'b0001, 2'b00);
        do_read(7'h08, 32'h0, 2'b00, 0);
    endtask

    task automatic test_rst_midtxn();
        int cnt = 0;
        awaddr = 7'h00; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1; rst = 1;
        @(posedge clk); #1;
        wvalid = 0; rst = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bvalid) cnt++;
            @(posedge clk); #1;
        end
        total++;
        if (cnt !== 0 || reg_val[31:0] !== 32'h0) begin
            bad++; $display("FAIL rst_midtxn: got bvalid_cycles=%0d reg0=%h expected 0 0", cnt, reg_val[31:0]);
        end
        begin
            int bc;
            do_write(7'h00, 32'hCAFE_F00D, 4'b1111, 0, 0, 2'b00, bc);
            total++;
            if (bc !== 1 || reg_val[31:0] !== 32'hCAFE_F00D) begin
                bad++; $display("FAIL post_rst_write: got cyc=%0d reg0=%h expected 1 cafef00d", bc, reg_val[31:0]);
            end
        end
    endtask

    task automatic test_irq_count();
`ifdef AXI4_LITE_IRQ_COUNT_EN
        wr(7'h0C, 32'h1, 4'b0001, 2'b00);
        wr(7'h14, 32'hFFFF_FFFF, 4'b1111, 2'b00);
        for (int p = 0; p < 3; p++) begin
            irq = 2'b01;
            cycles(1);
            irq = 2'b00;
            cycles(3);
            wr(7'h08, 32'h1, 4'b0001, 2'b00);
            cycles(2);
        end
        do_read(7'h14, 32'd3, 2'b00, 0);
        wr(7'h14, 32'h0, 4'b0000, 2'b00);
        do_read(7'h14, 32'd0, 2'b00, 0);
`else
        do_read(7'h14, 32'h0, 2'b10, 0);
        wr(7'h14, 32'h1, 4'b1111, 2'b10);
`endif
    endtask

    initial begin
        test_reset();
        test_write_strobe();
        test_map();
        test_level_irq();
        test_edge_w1c();
        test_set_wins();
        test_rst_midtxn();
        test_irq_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_reg_bank_irq_ctrl.md
Name: axi4_lite_reg_bank_irq_ctrl

Overview:
AXI4-Lite register bank with an integrated interrupt controller for PS-facing peripherals.
- Generalises the single raw-IRQ register to per-source edge/level capture, sticky pending bits, an enable mask, write-1-to-clear status and a registered, masked interrupt output.
- Sits between the PS AXI4-Lite interconnect and a peripheral's control/status registers and event lines.
- Contains its own AXI4-Lite slave handshake logic.

Parameters:
- num_regs, 2: number of general 32-bit registers, indices 0..num_regs-1.
- addr_width, 7: AXI byte-address width; register index = addr[addr_width-1:2].
- allow_write, {num_regs{1'b1}}: per-register bit; 1 = AXI-writable, 0 = register mirrors reg_in.
- num_irq, 1: number of interrupt sources, 1..32.
- irq_edge, {num_irq{1'b0}}: per-source bit; 1 = rising-edge capture, 0 = level capture.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- irq  in  num_irq  interrupt sources, synchronous to clk
- ps_irq  out  1  registered OR of (pending & enable)
- irq_reset  out  1  one-cycle pulse on any accepted write to IRQ_STATUS
- reg_val  out  32 x num_regs  current general register values
- reg_in  in  32 x num_regs  values for read-only registers
- s_axi_aw*/w*/b*/ar*/r*  standard AXI4-Lite slave channels: awaddr/araddr addr_width, data 32, wstrb 4, prot 3 (ignored), resp 2

Behaviour:
Clocking and reset:
- One clock; reset is synchronous and active-high (clk, rst).
- On rst: all ready/valid outputs 0, bresp = rresp = 0, rdata 0, reg_val 0, enable 0, pending 0, irq_d 0, ps_irq 0, irq_reset 0.
- Reset mid-transaction discards the in-flight transaction; no response is issued.

Register map (index = byte address / 4):
- 0..num_regs-1: general registers.
- num_regs: IRQ_STATUS, pending bits, W1C.
- num_regs+1: IRQ_ENABLE, read/write.
- num_regs+2: IRQ_RAW, read-only, current irq.
- Unused upper bits read 0.
- Any other index: reads return 0 with resp 2'b10 (SLVERR); writes are dropped with bresp 2'b10.
- Writes to read-only indices (allow_write bit 0, IRQ_RAW) are ignored with bresp OKAY.

Write channel:
- awready and wready are 1 when the corresponding channel is idle and bvalid = 0.
- AW and W are captured independently, in either order or in the same cycle. Each ready drops once its beat is captured.
- The cycle after both are held: the register update occurs, bvalid = 1.
- bvalid is held until bready. awready/wready reassert the cycle after the B handshake.
- wstrb[k] gates byte k for general registers and IRQ_ENABLE.
- For IRQ_STATUS, only strobed bytes clear.

Read channel:
- arready = 1 when rvalid = 0.
- On the AR handshake, rdata/rresp are registered and rvalid rises the next cycle (1-cycle latency).
- rvalid is held until rready; arready reasserts the cycle after.
- Reads and writes are independent and may complete in the same cycle.

Interrupt logic:
- irq_d <= irq every cycle.
- Set condition for source i:
  - irq_edge[i] = 1: irq[i] & ~irq_d[i].
  - irq_edge[i] = 0: irq[i].
- pending[i] <= set[i] | (pending[i] & ~clr[i]); set wins over a same-cycle W1C clear.
- ps_irq <= |(pending & enable), one cycle after pending/enable change. Masked pending bits remain set.
- irq_reset = 1 for exactly the cycle the IRQ_STATUS write is performed, regardless of wstrb.

Read-only general registers:
- reg_val[i] <= reg_in[i] every cycle when allow_write[i] = 0.

Optional Feature:
Macro: AXI4_LITE_IRQ_COUNT_EN
- Defined: adds IRQ_COUNT at index num_regs+3.
  - 32-bit counter incremented on each 0->1 transition of ps_irq; saturates at 0xFFFFFFFF.
  - Any write to IRQ_COUNT (data ignored) clears it to 0. An increment in the same cycle yields 1.
  - Reset value 0.
- Undefined: index num_regs+3 is out of range, so SLVERR on read and write.

Test Plan:
- AW at cycle 0, W at cycle 3, data 0xDEADBEEF, strb 4'b0101, index 0 → bvalid at cycle 4, reg_val[0] = 0x00AD00EF, bresp 0.
- enable = 0x1, irq_edge = 0, pulse irq[0] for 1 cycle → pending = 0x1 stays set after irq drops; ps_irq = 1 two cycles after the irq rise.
- Edge source held high 10 cycles, W1C 0x1 issued on cycle 5 → pending cleared, not re-set; ps_irq falls; irq_reset pulses once.
- W1C on a level source with irq still high → pending remains 1 (set wins); ps_irq stays 1.
- Read index num_regs+4, bready/rready held low 3 cycles → rresp = 2'b10, rdata = 0, rvalid held stable until rready.
- rst asserted with AW captured but W pending → no bvalid after reset; next full write completes normally. With AXI4_LITE_IRQ_COUNT_EN defined, three enabled pulses → IRQ_COUNT reads 3.
